// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
interface ifu_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
);

  logic                  ibus_req_o;
  logic [ADDR_WIDTH-1:0] ibus_addr_o;
  logic                  ibus_gnt_i;
  logic                  ibus_rvalid_i;
  logic [INST_WIDTH-1:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one fetch in flight, and
// holds the returned instruction in a one-entry buffer until IF/ID takes it.
// Redirects from execute flush the buffer and any wrong-path fetch.
module ifu_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  ifu_fetch_if.master           ibus,
  input  logic                  hold_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  discard_q;
  logic                  buf_valid_q;
  logic [INST_WIDTH-1:0] buf_inst_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;

  logic                  req_c;
  logic                  fire_c;
  logic                  resp_c;
  logic                  consume_c;
  logic                  buf_free_c;

  // Buffer view seen downstream; forced empty while reset is asserted.
  assign inst_valid_o = buf_valid_q & ~rst;
  assign inst_o       = inst_valid_o ? buf_inst_q : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? buf_addr_q : RESET_ADDR;

  assign consume_c  = inst_valid_o & ~hold_i;
  assign buf_free_c = ~inst_valid_o | consume_c;
  assign fire_c     = req_c & ibus.ibus_gnt_i;
  assign resp_c     = (state_q == ST_WAIT) & ibus.ibus_rvalid_i;

  assign ibus.ibus_req_o  = req_c;
  assign ibus.ibus_addr_o = pc_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one request in flight; a jump never blocks the response return.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_REQ:  if (fire_c) state_d = ST_WAIT;
      ST_WAIT: if (ibus.ibus_rvalid_i) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // FSM outputs: request only with room in the buffer and no redirect pending.
  always_comb begin
    req_c = 1'b0;
    if (state_q == ST_REQ) begin
      req_c = buf_free_c & ~jump_en_i & ~rst;
    end
  end

  // PC, in-flight tag, discard flag and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_ADDR;
      req_addr_q  <= RESET_ADDR;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_addr_q  <= RESET_ADDR;
    end else if (jump_en_i) begin
      pc_q        <= jump_addr_i & ALIGN_MASK;
      buf_valid_q <= 1'b0;
      // A response still to come belongs to the old path.
      if (state_q == ST_WAIT) begin
        discard_q <= ~ibus.ibus_rvalid_i;
      end
    end else begin
      if (fire_c) begin
        req_addr_q <= pc_q;
        pc_q       <= pc_q + PC_STEP;
      end
      if (resp_c) begin
        discard_q <= 1'b0;
      end
      if (resp_c && !discard_q) begin
        buf_valid_q <= 1'b1;
        buf_inst_q  <= ibus.ibus_rdata_i;
        buf_addr_q  <= req_addr_q;
      end else if (consume_c) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a memory responder drives the bus, a
// fetch-stream model predicts every bus request and buffer occupancy, and a
// monitor checks consumed instructions against the expected stream.
module tb_ifu_fetch;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int NPHASE = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  // Expected instruction stream: {inst, addr}.
  logic [63:0] exp_q[$];

  // Phase knobs: cycles, gnt %, hold %, jump %, max extra rvalid delay, reset %.
  int ncyc   [NPHASE] = '{20, 200, 300, 300, 120};
  int gnt_pct[NPHASE] = '{100, 100, 70, 60, 100};
  int hld_pct[NPHASE] = '{0, 40, 30, 20, 0};
  int jmp_pct[NPHASE] = '{0, 0, 10, 15, 6};
  int dly_max[NPHASE] = '{0, 2, 2, 2, 0};
  int rst_pct[NPHASE] = '{0, 0, 0, 2, 0};

  ifu_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) ibus ();

  ifu_fetch #(
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW),
    .RESET_ADDR(RESET_ADDR),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ibus        (ibus),
    .hold_i      (hold),
    .jump_en_i   (jump_en),
    .jump_addr_i (jump_addr),
    .inst_valid_o(inst_valid),
    .inst_o      (inst),
    .inst_addr_o (inst_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target(input int p);
    logic [31:0] t;
    if (p == 4) begin
      t = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
    end else begin
      case ($urandom_range(0, 4))
        0:       t = 32'h0000_1003;
        1:       t = 32'h0000_0200;
        2:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        3:       t = 32'h0000_0100 | 32'($urandom_range(0, 255));
        default: t = $urandom;
      endcase
    end
    return t;
  endfunction

  // Stimulus and memory responder.
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    cnt = 0;
    pend_addr = '0;
    rst = 1'b1;
    hold = 1'b0;
    jump_en = 1'b0;
    jump_addr = '0;
    ibus.ibus_gnt_i = 1'b0;
    ibus.ibus_rvalid_i = 1'b0;
    ibus.ibus_rdata_i = '0;
    repeat (3) @(posedge clk);
    for (int p = 0; p < NPHASE + 1; p++) begin
      for (int c = 0; c < ((p < NPHASE) ? ncyc[p] : 12); c++) begin
        @(posedge clk);
        #1;
        rst = (p < NPHASE) && ($urandom_range(0, 99) < rst_pct[p]);
        if (rst) begin
          pend = 1'b0;
          ibus.ibus_rvalid_i = 1'b0;
        end else if (pend && cnt == 0) begin
          ibus.ibus_rvalid_i = 1'b1;
          ibus.ibus_rdata_i = mem_data(pend_addr);
          pend = 1'b0;
        end else begin
          ibus.ibus_rvalid_i = 1'b0;
          ibus.ibus_rdata_i = $urandom;
          if (pend) cnt--;
        end
        if (p < NPHASE) begin
          ibus.ibus_gnt_i = $urandom_range(0, 99) < gnt_pct[p];
          hold = $urandom_range(0, 99) < hld_pct[p];
          jump_en = $urandom_range(0, 99) < jmp_pct[p];
          jump_addr = jump_en ? pick_target(p) : $urandom;
        end else begin
          ibus.ibus_gnt_i = 1'b1;
          hold = 1'b0;
          jump_en = 1'b0;
        end
        @(negedge clk);
        if (ibus.ibus_req_o && ibus.ibus_gnt_i) begin
          pend = 1'b1;
          pend_addr = ibus.ibus_addr_o;
          cnt = (p < NPHASE) ? $urandom_range(0, dly_max[p]) : 0;
        end
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (consumed < 50) begin
      errors++;
      $display("FAIL progress: consumed %0d instructions, required at least 50", consumed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Fetch-stream model: predicts requests and buffer occupancy from the
  // observed bus and control inputs, and produces the expected stream.
  initial begin
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_wrong;
    bit          m_bvalid;
    bit          exp_req;
    m_pc = RESET_ADDR;
    m_out_addr = '0;
    m_out = 1'b0;
    m_wrong = 1'b0;
    m_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req", 32'(ibus.ibus_req_o), 32'(1'b0));
        check("rst_valid", 32'(inst_valid), 32'(1'b0));
        check("rst_inst", inst, NOP_INST);
        check("rst_inst_addr", inst_addr, RESET_ADDR);
        m_pc = RESET_ADDR;
        m_out = 1'b0;
        m_wrong = 1'b0;
        m_bvalid = 1'b0;
        exp_q.delete();
      end else begin
        exp_req = !m_out && !jump_en && (!m_bvalid || !hold);
        check("ibus_req", 32'(ibus.ibus_req_o), 32'(exp_req));
        if (exp_req) check("ibus_addr", ibus.ibus_addr_o, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_bvalid));
        if (!m_bvalid) begin
          check("idle_inst", inst, NOP_INST);
          check("idle_inst_addr", inst_addr, RESET_ADDR);
        end
        if (m_bvalid && !hold) m_bvalid = 1'b0;
        if (jump_en) begin
          m_bvalid = 1'b0;
          exp_q.delete();
          m_pc = {jump_addr[31:2], 2'b00};
          if (m_out) begin
            if (ibus.ibus_rvalid_i) begin
              m_out = 1'b0;
              m_wrong = 1'b0;
            end else begin
              m_wrong = 1'b1;
            end
          end
        end else begin
          if (m_out && ibus.ibus_rvalid_i) begin
            m_out = 1'b0;
            if (m_wrong) begin
              m_wrong = 1'b0;
            end else begin
              exp_q.push_back({mem_data(m_out_addr), m_out_addr});
              m_bvalid = 1'b1;
            end
          end
          if (exp_req && ibus.ibus_gnt_i) begin
            m_out = 1'b1;
            m_out_addr = m_pc;
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Monitor: every instruction taken by IF/ID must be the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && !hold && !jump_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL consume_unexpected: got inst %h addr %h, expected no instruction", inst, inst_addr);
        end else begin
          e = exp_q.pop_front();
          check("consume_inst", inst, e[63:32]);
          check("consume_addr", inst_addr, e[31:0]);
          consumed++;
        end
      end
    end
  end

endmodule
